c17_activity_sequencer: RTL and testbench
=========================================

Name: c17_activity_sequencer

Overview:
- Sequences test vectors into an external C17-class combinational core: 5 primary inputs, 2 outputs.
- Measures switching activity per measurement window as a power proxy for the power-aware synthesis flow:
  - input-bit toggles between successive applied vectors;
  - output-bit toggles between successive sampled responses.
- Vectors arrive on a valid/ready stream. A completed window is reported on a second valid/ready stream.

Parameters:
- WIN_LEN, 16, vectors per window before auto-close; legal range 1..255.
- CNT_W, 8, width of toggle and vector counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; opens a window; honoured only in IDLE.
- stop  in  1  closes the window early; honoured only in RUN.
- vec_valid  in  1  vector available.
- vec_data  in  5  vector; bit0=1GAT, bit1=2GAT, bit2=3GAT, bit3=6GAT, bit4=7GAT.
- vec_ready  out  1  block accepts a vector this cycle.
- core_in  out  5  registered drive to the core inputs.
- core_out  in  2  core response; bit0=22GAT, bit1=23GAT.
- busy  out  1  state is not IDLE.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  report consumer ready.
- rpt_in_tog  out  CNT_W  input toggles in the window.
- rpt_out_tog  out  CNT_W  output toggles in the window.
- rpt_vec_cnt  out  CNT_W  vectors applied in the window.

Behaviour:
- Reset values (async, all outputs): core_in=0, vec_ready=0, busy=0, rpt_valid=0, all rpt_* = 0, state=IDLE.
  - Internal prev_out=0, all counters=0, sample flag=0.
- Reset asserted mid-window discards the window. No report is produced.
- States:
  - IDLE: vec_ready=0.
    - start=1 → RUN. Clear in_tog, out_tog, vec_cnt.
    - core_in and prev_out are kept, so activity is continuous across windows.
  - RUN: vec_ready=1 (combinational, equal to state==RUN).
    - Accept when vec_valid&vec_ready.
    - On accept: core_in<=vec_data; in_tog += popcount(vec_data ^ core_in); vec_cnt += 1; sample flag<=1.
    - Otherwise sample flag<=0.
    - One vector per cycle, no bubbles required.
    - Close condition: (accept and vec_cnt+1==WIN_LEN) or stop=1 → DRAIN.
    - stop in the same cycle as an accept: the vector is counted and applied, then → DRAIN.
    - stop with zero vectors accepted → DRAIN; the report shows all-zero counts.
  - DRAIN: vec_ready=0. Lasts exactly one cycle so the final sample completes. → REPORT.
  - REPORT: rpt_valid=1 and rpt_* hold stable until rpt_ready=1.
    - The handshake cycle → IDLE with rpt_valid=0 next cycle.
    - rpt_ready while rpt_valid=0 is ignored.
- Sampling pipeline:
  - The core is combinational, so core_out reflects core_in in the cycle after accept.
  - When sample flag=1: out_tog += popcount(core_out ^ prev_out); prev_out<=core_out.
  - Sampling is active in RUN and DRAIN. Its latency is 1 cycle after the accept edge.
- Arithmetic:
  - popcount widths are 3 bits (input) and 2 bits (output), zero-extended to CNT_W.
  - Each adder saturates at all-ones. No wrap.
- start in RUN/DRAIN/REPORT and stop outside RUN are ignored.
- rpt_* values are latched on entry to REPORT and otherwise hold their previous value.

Test Plan:
- Reset, then start, then vectors 5'b00010, 5'b01110, 5'b00000 back-to-back, then stop one cycle after the last accept.
  - Expected core_out sequence 2'b11, 2'b00, 2'b00.
  - Report: in_tog=6, out_tog=4, vec_cnt=3.
  - rpt_valid holds with rpt_ready=0 for 5 cycles; values stable throughout.
- WIN_LEN=4: start, then 4 vectors with vec_valid held high.
  - vec_ready drops the cycle after the 4th accept.
  - busy stays high through DRAIN and REPORT.
  - Report vec_cnt=4, with no stop needed.
- start, then stop immediately.
  - Report in_tog=0, out_tog=0, vec_cnt=0; core_in unchanged.
- stop asserted in the same cycle as an accept of 5'b11111 after reset.
  - Report in_tog=5, vec_cnt=1.
  - out_tog equals popcount of the core response to 5'b11111 (2'b01 → 1).
- CNT_W=3, WIN_LEN=8: alternate vectors 5'b11111 and 5'b00000.
  - in_tog saturates at 7 with no wrap; vec_cnt=7 after saturation.
- rst_n pulled low while in RUN with 2 vectors accepted.
  - All outputs return to reset values asynchronously. No rpt_valid follows.
  - A new start yields a fresh window counted from core_in=0.

Source files
------------

// File: rtl/c17_activity_sequencer_if.sv
// Vector stream, C17 core drive/response and window report stream
// of the C17 activity sequencer.
interface c17_activity_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             vec_valid;
    logic             vec_ready;
    logic [4:0]       vec_data;
    logic [4:0]       core_in;
    logic [1:0]       core_out;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_in_tog;
    logic [CNT_W-1:0] rpt_out_tog;
    logic [CNT_W-1:0] rpt_vec_cnt;

    modport master (
        output vec_valid, vec_data, core_out, rpt_ready,
        input  vec_ready, core_in, rpt_valid, rpt_in_tog, rpt_out_tog, rpt_vec_cnt
    );

    modport slave (
        input  vec_valid, vec_data, core_out, rpt_ready,
        output vec_ready, core_in, rpt_valid, rpt_in_tog, rpt_out_tog, rpt_vec_cnt
    );
endinterface

// File: rtl/c17_activity_sequencer.sv
// Applies vectors to an external C17 core and counts input/output bit toggles
// per measurement window, reporting each closed window on a valid/ready stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no window open; core_in and prev_out keep their values
// ST_RUN    | accepting vectors, counting toggles
// ST_DRAIN  | one cycle so the response to the last vector is sampled
// ST_REPORT | report presented until rpt_ready
module c17_activity_sequencer #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stop,
    output logic                           busy,
    c17_activity_sequencer_if.slave        bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // Wide enough that vec_cnt+1 never wraps before meeting WIN_LEN.
    localparam int CMP_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] in_tog;
    logic [CNT_W-1:0] out_tog;
    logic [CNT_W-1:0] vec_cnt;
    logic [1:0]       prev_out;
    logic             sample;

    logic             accept;
    logic             close_win;
    logic [CNT_W-1:0] in_tog_nxt;
    logic [CNT_W-1:0] out_tog_nxt;
    logic [CNT_W-1:0] vec_cnt_nxt;
    logic [CMP_W-1:0] cnt_plus1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       b);
        logic [CNT_W+2:0] s;
        logic [CNT_W+2:0] lim;
        lim = {3'b000, {CNT_W{1'b1}}};
        s   = {3'b000, a} + {{CNT_W{1'b0}}, b};
        return (s > lim) ? lim[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction

    function automatic logic [2:0] pop5(input logic [4:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
    endfunction

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    assign bus.vec_ready = (state == ST_RUN);
    assign bus.rpt_valid = (state == ST_REPORT);
    assign busy          = (state != ST_IDLE);

    always_comb begin
        accept      = bus.vec_valid && bus.vec_ready;
        in_tog_nxt  = accept ? sat_add(in_tog, pop5(bus.vec_data ^ bus.core_in)) : in_tog;
        out_tog_nxt = sample ? sat_add(out_tog, {1'b0, pop2(bus.core_out ^ prev_out)}) : out_tog;
        vec_cnt_nxt = accept ? sat_add(vec_cnt, 3'd1) : vec_cnt;
        cnt_plus1   = {{(CMP_W-CNT_W){1'b0}}, vec_cnt} + CMP_W'(1);
        close_win   = (accept && (cnt_plus1 == CMP_W'(WIN_LEN))) || stop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            bus.core_in     <= '0;
            prev_out        <= '0;
            sample          <= 1'b0;
            in_tog          <= '0;
            out_tog         <= '0;
            vec_cnt         <= '0;
            bus.rpt_in_tog  <= '0;
            bus.rpt_out_tog <= '0;
            bus.rpt_vec_cnt <= '0;
        end else begin
            sample  <= accept;
            in_tog  <= in_tog_nxt;
            out_tog <= out_tog_nxt;
            vec_cnt <= vec_cnt_nxt;
            if (sample) prev_out <= bus.core_out;
            if (accept) bus.core_in <= bus.vec_data;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        in_tog  <= '0;
                        out_tog <= '0;
                        vec_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (close_win) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Latch next values so the final response sample is included.
                    state           <= ST_REPORT;
                    bus.rpt_in_tog  <= in_tog_nxt;
                    bus.rpt_out_tog <= out_tog_nxt;
                    bus.rpt_vec_cnt <= vec_cnt_nxt;
                end
                ST_REPORT: begin
                    if (bus.rpt_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c17_activity_sequencer.sv
// Randomized self-checking bench: three sequencer instances with different
// window/counter sizes, each driving a behavioural C17 core.
module tb_c17_activity_sequencer;
    localparam int WL [3] = '{16, 4, 8};
    localparam int CW [3] = '{8, 8, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] start_s, stop_s, busy_s, vv_s, vr_s, rv_s, rr_s;
    logic [4:0] vd_s [3];
    logic [4:0] ci_s [3];
    logic [7:0] ri_s [3];
    logic [7:0] ro_s [3];
    logic [7:0] rc_s [3];

    int errors = 0;
    int checks = 0;

    logic [4:0] mdl_in  [3];
    logic [1:0] mdl_out [3];
    logic [4:0] vq [$];

    // Gate-level C17: bit0=1GAT bit1=2GAT bit2=3GAT bit3=6GAT bit4=7GAT.
    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[0] & v[2]);
        n11 = ~(v[2] & v[3]);
        n16 = ~(v[1] & n11);
        n19 = ~(n11 & v[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        c17_activity_sequencer_if #(.CNT_W(CW[g])) bus ();
        assign bus.vec_valid = vv_s[g];
        assign bus.vec_data  = vd_s[g];
        assign bus.rpt_ready = rr_s[g];
        assign bus.core_out  = c17(bus.core_in);
        assign vr_s[g] = bus.vec_ready;
        assign rv_s[g] = bus.rpt_valid;
        assign ci_s[g] = bus.core_in;
        assign ri_s[g] = 8'(bus.rpt_in_tog);
        assign ro_s[g] = 8'(bus.rpt_out_tog);
        assign rc_s[g] = 8'(bus.rpt_vec_cnt);

        c17_activity_sequencer #(.WIN_LEN(WL[g]), .CNT_W(CW[g])) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_s[g]),
            .stop  (stop_s[g]),
            .busy  (busy_s[g]),
            .bus   (bus.slave)
        );
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < 3; k++) begin
            chk("rst_core_in", k, 32'(ci_s[k]), 0);
            chk("rst_vec_ready", k, 32'(vr_s[k]), 0);
            chk("rst_busy", k, 32'(busy_s[k]), 0);
            chk("rst_rpt_valid", k, 32'(rv_s[k]), 0);
            chk("rst_rpt_in", k, 32'(ri_s[k]), 0);
            chk("rst_rpt_out", k, 32'(ro_s[k]), 0);
            chk("rst_rpt_cnt", k, 32'(rc_s[k]), 0);
        end
    endtask

    // stop_mode: 0 = auto-close at WIN_LEN, 1 = stop with last accept, 2 = stop one cycle later.
    task automatic run_window(input int k, input int stop_mode, input bit gaps, input int hold);
        int n, maxv, ei, eo, ec, t;
        n    = vq.size();
        maxv = (1 << CW[k]) - 1;
        ei = 0; eo = 0; ec = 0;
        foreach (vq[i]) begin
            ei += $countones(vq[i] ^ mdl_in[k]);
            eo += $countones(c17(vq[i]) ^ mdl_out[k]);
            mdl_in[k]  = vq[i];
            mdl_out[k] = c17(vq[i]);
            ec++;
        end
        if (ei > maxv) ei = maxv;
        if (eo > maxv) eo = maxv;
        if (ec > maxv) ec = maxv;

        @(negedge clk);
        rr_s[k]    = 1'b0;
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        chk("busy_run", k, 32'(busy_s[k]), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                vv_s[k] = 1'b0;
                @(negedge clk);
            end
            vv_s[k]   = 1'b1;
            vd_s[k]   = vq[i];
            stop_s[k] = (stop_mode == 1 && i == n - 1);
            chk("vec_ready_run", k, 32'(vr_s[k]), 1);
            @(negedge clk);
        end
        stop_s[k] = 1'b0;
        if (stop_mode == 0) begin
            chk("drain_ready", k, 32'(vr_s[k]), 0);
            chk("drain_busy", k, 32'(busy_s[k]), 1);
        end
        vv_s[k] = 1'b0;
        if (stop_mode == 2) begin
            stop_s[k] = 1'b1;
            @(negedge clk);
            stop_s[k] = 1'b0;
        end

        t = 0;
        while (!rv_s[k] && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("rpt_wait", k, 32'(rv_s[k]), 1);
        for (int h = 0; h <= hold; h++) begin
            chk("rpt_valid_hold", k, 32'(rv_s[k]), 1);
            chk("rpt_in_tog", k, 32'(ri_s[k]), 32'(ei));
            chk("rpt_out_tog", k, 32'(ro_s[k]), 32'(eo));
            chk("rpt_vec_cnt", k, 32'(rc_s[k]), 32'(ec));
            chk("busy_report", k, 32'(busy_s[k]), 1);
            chk("ready_report", k, 32'(vr_s[k]), 0);
            if (h < hold) begin
                start_s[k] = 1'($urandom_range(0, 1));
                stop_s[k]  = 1'($urandom_range(0, 1));
                @(negedge clk);
                start_s[k] = 1'b0;
                stop_s[k]  = 1'b0;
            end
        end
        rr_s[k] = 1'b1;
        @(negedge clk);
        rr_s[k] = 1'($urandom_range(0, 1));
        chk("rpt_valid_after", k, 32'(rv_s[k]), 0);
        chk("busy_idle", k, 32'(busy_s[k]), 0);
        chk("core_in_hold", k, 32'(ci_s[k]), 32'(mdl_in[k]));
        @(negedge clk);
        chk("idle_stays", k, 32'(busy_s[k]), 0);
        rr_s[k] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, n, mode;
        start_s = '0; stop_s = '0; vv_s = '0; rr_s = '0;
        for (int i = 0; i < 3; i++) begin
            vd_s[i] = '0; mdl_in[i] = '0; mdl_out[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Back-to-back vectors, stop one cycle later, report held 5 cycles.
        vq.delete();
        vq.push_back(5'b00010); vq.push_back(5'b01110); vq.push_back(5'b00000);
        run_window(0, 2, 1'b0, 5);

        // Auto-close at WIN_LEN=4 with vec_valid held.
        vq.delete();
        for (int i = 0; i < 4; i++) vq.push_back(5'($urandom_range(0, 31)));
        run_window(1, 0, 1'b0, 1);

        // Empty window.
        vq.delete();
        run_window(0, 2, 1'b0, 0);

        // Reset in the middle of a window after two accepts.
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        vv_s[0] = 1'b1; vd_s[0] = 5'b10101;
        @(negedge clk);
        vd_s[0] = 5'b00111;
        @(negedge clk);
        vv_s[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        for (int i = 0; i < 3; i++) begin
            mdl_in[i] = '0; mdl_out[i] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rpt_after_reset", 0, 32'(rv_s[0]), 0);
        end

        // Fresh window: stop in the same cycle as accepting 11111.
        vq.delete();
        vq.push_back(5'b11111);
        run_window(0, 1, 1'b0, 2);

        // CNT_W=3 saturation with alternating all-ones/all-zeros.
        vq.delete();
        for (int i = 0; i < 8; i++) vq.push_back((i % 2 == 0) ? 5'b11111 : 5'b00000);
        run_window(2, 0, 1'b0, 1);

        // Randomized windows across all instances.
        repeat (18) begin
            k = $urandom_range(0, 2);
            n = $urandom_range(0, WL[k]);
            if (n == WL[k])  mode = 0;
            else if (n == 0) mode = 2;
            else             mode = $urandom_range(1, 2);
            vq.delete();
            for (int i = 0; i < n; i++) vq.push_back(5'($urandom_range(0, 31)));
            run_window(k, mode, 1'b1, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
